// File: rtl/button_event_ctrl_pkg.sv
// rtl/button_event_ctrl_pkg.sv - register offsets, defaults and popcount helper for button_event_ctrl
package button_event_ctrl_pkg;

    localparam logic [11:0] BTN_LEVEL_OFF = 12'h000;
    localparam logic [11:0] BTN_PEVT_OFF  = 12'h004;
    localparam logic [11:0] BTN_PCNT_OFF  = 12'h008;
    localparam logic [11:0] BTN_REVT_OFF  = 12'h00C;

    localparam int DEB_CYCLES_DEFAULT = 50000;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// rtl/button_event_ctrl_if.sv - bridge-side register bus for button_event_ctrl
interface button_event_ctrl_if;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output wen, output wdata, input rdata);
    modport slave  (input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/button_event_ctrl_debounce.sv
// rtl/button_event_ctrl_debounce.sv - btn_debounce: two-flop synchroniser plus hold-time debouncer for one button
module btn_debounce
    import button_event_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pulses look one edge ahead so event flags update on the same edge as stable.
    assign stable     = stable_q;
    assign rise_pulse = ~stable_q & stable_d;
    assign fall_pulse = stable_q & ~stable_d;

endmodule

// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounced button press-event peripheral; BTN_RELEASE_EVT_EN adds release flags at 0x00C
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int NBTN       = 5,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    button_event_ctrl_if.slave   bus,
    input  logic [NBTN-1:0]      button
);
    logic [NBTN-1:0]  stable, rise, fall;
    logic [NBTN-1:0]  pevt_q, pevt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W+3:0] pcnt_sum;
    logic [11:0]      word_addr;
    logic             wr_pevt, wr_pcnt;
    logic [31:0]      rdata_w;
    logic             unused_bits;

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk        (clk),
            .rst        (rst),
            .btn        (button[gi]),
            .stable     (stable[gi]),
            .rise_pulse (rise[gi]),
            .fall_pulse (fall[gi])
        );
    end

    assign word_addr   = {bus.addr[11:2], 2'b00};
    assign wr_pevt     = bus.wen && (word_addr == BTN_PEVT_OFF);
    assign wr_pcnt     = bus.wen && (word_addr == BTN_PCNT_OFF);
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:NBTN]};

    // Set is OR-ed after the clear so a coincident press survives a W1C.
    assign pevt_d = (pevt_q & ~(wr_pevt ? bus.wdata[NBTN-1:0] : '0)) | rise;

    // Sum in a wider field so the saturation test sees the carry.
    assign pcnt_sum = (wr_pcnt ? '0 : {4'b0000, pcnt_q}) + (CNT_W+4)'(popcount8(8'(rise)));
    assign pcnt_d   = (pcnt_sum > {4'b0000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : pcnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pevt_q <= '0;
            pcnt_q <= '0;
        end else begin
            pevt_q <= pevt_d;
            pcnt_q <= pcnt_d;
        end
    end

`ifdef BTN_RELEASE_EVT_EN
    logic [NBTN-1:0] revt_q, revt_d;
    logic            wr_revt;

    assign wr_revt = bus.wen && (word_addr == BTN_REVT_OFF);
    assign revt_d  = (revt_q & ~(wr_revt ? bus.wdata[NBTN-1:0] : '0)) | fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            revt_q <= '0;
        end else begin
            revt_q <= revt_d;
        end
    end
`else
    logic unused_fall;
    assign unused_fall = ^fall;
`endif

    always_comb begin
        rdata_w = '0;
        case (word_addr)
            BTN_LEVEL_OFF: rdata_w = 32'(stable);
            BTN_PEVT_OFF:  rdata_w = 32'(pevt_q);
            BTN_PCNT_OFF:  rdata_w = 32'(pcnt_q);
`ifdef BTN_RELEASE_EVT_EN
            BTN_REVT_OFF:  rdata_w = 32'(revt_q);
`endif
            default:       rdata_w = '0;
        endcase
    end

    assign bus.rdata = rdata_w;

endmodule
